// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
//   Turns a raster-order pixel stream into 3x3 windows for a Sobel operator.
//   Two line buffers hold rows r-1 and r-2. Two column registers hold the
//   previous two columns of the window. One window is emitted for every pixel
//   at row >= 2 and column >= 2. Pixel values pass through unchanged.
//
// Parameters
//   IMG_WIDTH  pixels per row   (3..4096)
//   IMG_HEIGHT rows per frame   (3..4096)
//   PIX_W      bits per pixel
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   pix_valid/pix_ready  input pixel handshake; pix_data is the pixel
//   sof                  start of frame, marks the accepted pixel as (0,0)
//   win_valid/win_ready  window handshake
//   win0..win8           3x3 window, row-major; win0 top-left, win8 bottom-right
//   frame_done           one-cycle pulse after the last pixel of a frame
//   win_count            (only with SOBEL_WIN_COUNT_EN) 20-bit count of window
//                        handshakes, cleared by reset and by an accepted sof
//
// Optional feature macro: SOBEL_WIN_COUNT_EN
// -----------------------------------------------------------------------------
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int PIX_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             sof,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [PIX_W-1:0] win0,
    output logic [PIX_W-1:0] win1,
    output logic [PIX_W-1:0] win2,
    output logic [PIX_W-1:0] win3,
    output logic [PIX_W-1:0] win4,
    output logic [PIX_W-1:0] win5,
    output logic [PIX_W-1:0] win6,
    output logic [PIX_W-1:0] win7,
    output logic [PIX_W-1:0] win8,
`ifdef SOBEL_WIN_COUNT_EN
    output logic [19:0]      win_count,
`endif
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Position counters: address of the next pixel to be accepted
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // Line buffers (row r-1 and row r-2) and previous two window columns.
    // Index 0 = top, 1 = middle, 2 = bottom of the column.
    logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] r_lb2 [IMG_WIDTH];
    logic [PIX_W-1:0] r_s1  [3];
    logic [PIX_W-1:0] r_s2  [3];

    // Output window and status registers
    logic [PIX_W-1:0] r_win [9];
    logic             r_win_valid;
    logic             r_frame_done;

    logic             w_accept;
    logic [CW-1:0]    w_pos_col;
    logic [RW-1:0]    w_pos_row;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_load;
    logic [PIX_W-1:0] w_top;
    logic [PIX_W-1:0] w_mid;
    logic [PIX_W-1:0] w_new_win [9];

    // A window can only be replaced when it is being consumed in the same cycle
    assign pix_ready = !r_win_valid || win_ready;

    // Effective position of the incoming pixel (sof forces 0,0) and the window it completes
    always_comb begin
        w_accept = pix_valid && pix_ready;
        if (sof) begin
            w_pos_col = '0;
            w_pos_row = '0;
        end else begin
            w_pos_col = r_col;
            w_pos_row = r_row;
        end
        w_col_last = (w_pos_col == COL_LAST);
        w_row_last = (w_pos_row == ROW_LAST);
        w_load     = w_accept && (w_pos_row >= RW'(2)) && (w_pos_col >= CW'(2));
        w_top      = r_lb2[w_pos_col];
        w_mid      = r_lb1[w_pos_col];
        // Left column from r_s2 (c-2), middle from r_s1 (c-1), right is the new column
        w_new_win[0] = r_s2[0];
        w_new_win[1] = r_s1[0];
        w_new_win[2] = w_top;
        w_new_win[3] = r_s2[1];
        w_new_win[4] = r_s1[1];
        w_new_win[5] = w_mid;
        w_new_win[6] = r_s2[2];
        w_new_win[7] = r_s1[2];
        w_new_win[8] = pix_data;
    end

    // Column/row counters and the end-of-frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    if (w_row_last) begin
                        r_row <= '0;
                    end else begin
                        r_row <= w_pos_row + RW'(1);
                    end
                end else begin
                    r_col <= w_pos_col + CW'(1);
                    r_row <= w_pos_row;
                end
            end
        end
    end

    // Line buffers and column history; contents are never observable before
    // being overwritten, so they carry no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[w_pos_col] <= w_mid;
            r_lb1[w_pos_col] <= pix_data;
            r_s2[0] <= r_s1[0];
            r_s2[1] <= r_s1[1];
            r_s2[2] <= r_s1[2];
            r_s1[0] <= w_top;
            r_s1[1] <= w_mid;
            r_s1[2] <= pix_data;
        end
    end

    // Window registers and valid flag; the window holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            if (w_load) begin
                r_win_valid <= 1'b1;
                for (int i = 0; i < 9; i++) begin
                    r_win[i] <= w_new_win[i];
                end
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

`ifdef SOBEL_WIN_COUNT_EN
    logic [19:0] r_win_count;

    // Window handshake counter, restarted by each accepted start of frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_count <= 20'd0;
        end else if (w_accept && sof) begin
            r_win_count <= 20'd0;
        end else if (r_win_valid && win_ready) begin
            r_win_count <= r_win_count + 20'd1;
        end
    end

    assign win_count = r_win_count;
`endif

    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
    assign win0 = r_win[0];
    assign win1 = r_win[1];
    assign win2 = r_win[2];
    assign win3 = r_win[3];
    assign win4 = r_win[4];
    assign win5 = r_win[5];
    assign win6 = r_win[6];
    assign win7 = r_win[7];
    assign win8 = r_win[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_gen
//   Directed bench for sobel_window_gen on a 4x4 image. A negedge monitor logs
//   every window handshake and frame_done pulse. Each window is compared with
//   a window built from the known raster values.
// -----------------------------------------------------------------------------
module tb_sobel_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic          win_ready = 1'b1;
    logic [PW-1:0] pix_data = '0;
    logic          pix_ready;
    logic          win_valid;
    logic          frame_done;
    logic [PW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
`ifdef SOBEL_WIN_COUNT_EN
    logic [19:0]   win_count;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    logic [80:0]   got_q [$];
    int            fd_cnt = 0;
    logic [80:0]   w_pack;
    int            tl_tab [4] = '{0, 1, 4, 5};

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .sof(sof),
        .win_valid(win_valid), .win_ready(win_ready),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
        .win5(win5), .win6(win6), .win7(win7), .win8(win8),
`ifdef SOBEL_WIN_COUNT_EN
        .win_count(win_count),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign w_pack = {win0, win1, win2, win3, win4, win5, win6, win7, win8};

    // Log window handshakes and frame_done pulses away from the active edge
    always @(negedge clk) begin
        if (win_valid && win_ready) got_q.push_back(w_pack);
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window whose top-left raster index is tl, for a frame of values base..base+15
    function automatic logic [80:0] exp_win(input int base, input int tl);
        logic [80:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p[(8-i)*9 +: 9] = PW'(base + tl + (i / 3) * W + (i % 3));
        return p;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input bit s, input int gap);
        bit acc;
        int n;
        idle(gap);
        pix_valid = 1'b1;
        pix_data  = PW'(d);
        sof       = s;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 96'd0, 96'd1);
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic check_frames(input string tag, input int q0, input int fd0, input int base, input int nfr);
        chk({tag, "_nwin"}, 96'(got_q.size() - q0), 96'(4 * nfr));
        for (int k = 0; k < 4 * nfr; k++) begin
            if (q0 + k < got_q.size())
                chk($sformatf("%s_win%0d", tag, k), 96'(got_q[q0 + k]), 96'(exp_win(base, tl_tab[k % 4])));
        end
        chk({tag, "_fdone"}, 96'(fd_cnt - fd0), 96'(nfr));
    endtask

    initial begin
        int q0;
        int fd0;

        // Reset state
        idle(3);
        chk("rst_wvalid", 96'(win_valid), 96'd0);
        chk("rst_fdone", 96'(frame_done), 96'd0);
        chk("rst_win", 96'(w_pack), 96'd0);
        chk("rst_pready", 96'(pix_ready), 96'd1);
        rst = 1'b0;
        idle(2);

        // Plain frame 0..15, consumer always ready
        q0 = got_q.size(); fd0 = fd_cnt;
        for (int i = 0; i < 16; i++) begin
            send(i, i == 0, 0);
            if (i == 9)  chk("t1_no_win_c1", 96'(win_valid), 96'd0);
            if (i == 10) begin
                chk("t1_latency", 96'(win_valid), 96'd1);
                chk("t1_first", 96'(w_pack), 96'(exp_win(0, 0)));
            end
            if (i == 14) chk("t1_no_fdone_early", 96'(frame_done), 96'd0);
            if (i == 15) chk("t1_fdone_hi", 96'(frame_done), 96'd1);
        end
        idle(1);
        chk("t1_fdone_lo", 96'(frame_done), 96'd0);
        idle(3);
        check_frames("t1", q0, fd0, 0, 1);
`ifdef SOBEL_WIN_COUNT_EN
        chk("t1_count", 96'(win_count), 96'd4);
`endif

        // Stall for 5 cycles after the first window
        win_ready = 1'b0;
        q0 = got_q.size(); fd0 = fd_cnt;
        for (int i = 0; i < 11; i++) begin
            send(i, i == 0, 0);
`ifdef SOBEL_WIN_COUNT_EN
            if (i == 0) chk("t2_count_clr", 96'(win_count), 96'd0);
`endif
        end
        pix_valid = 1'b1;
        pix_data  = PW'(11);
        for (int c = 0; c < 5; c++) begin
            chk("t2_hold_valid", 96'(win_valid), 96'd1);
            chk("t2_hold_pready", 96'(pix_ready), 96'd0);
            chk("t2_hold_win", 96'(w_pack), 96'(exp_win(0, 0)));
            idle(1);
        end
        pix_valid = 1'b0;
        win_ready = 1'b1;
        for (int i = 11; i < 16; i++) send(i, 1'b0, 0);
        idle(3);
        check_frames("t2", q0, fd0, 0, 1);

        // Two back-to-back frames with random input gaps
        q0 = got_q.size(); fd0 = fd_cnt;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) send(i, i == 0, int'($urandom_range(0, 3)));
        idle(3);
        check_frames("t3", q0, fd0, 0, 2);

        // Frame restarted by sof on its 7th pixel
        q0 = got_q.size(); fd0 = fd_cnt;
        for (int i = 0; i < 6; i++) send(i, i == 0, 0);
        for (int i = 0; i < 16; i++) send(100 + i, i == 0, 0);
        idle(3);
        check_frames("t4", q0, fd0, 100, 1);

        // Asynchronous reset while a window is pending
        win_ready = 1'b0;
        for (int i = 0; i < 11; i++) send(i, i == 0, 0);
        chk("t5_pending", 96'(win_valid), 96'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_valid", 96'(win_valid), 96'd0);
        chk("t5_async_win", 96'(w_pack), 96'd0);
        #1 rst = 1'b0;
        win_ready = 1'b1;
        idle(1);
        // No sof: the first pixel after reset must land at (0,0); full-range values
        q0 = got_q.size(); fd0 = fd_cnt;
        for (int i = 0; i < 16; i++) send(496 + i, 1'b0, 0);
        idle(3);
        check_frames("t5", q0, fd0, 496, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64, pixels per row (legal: 3 to 4096).
REQ-002 SHALL have parameter IMG_HEIGHT, default 64, rows per frame (legal: 3 to 4096).
REQ-003 SHALL have parameter PIX_W, default 9, bits per pixel and per window element.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 pix_valid  input  1  pix_data is valid.
REQ-008 pix_ready  output  1  block accepts a pixel when pix_valid && pix_ready.
REQ-009 pix_data  input  PIX_W  raster-order pixel.
REQ-010 sof  input  1  start of frame, qualified by pix_valid && pix_ready.
REQ-011 win_valid  output  1  window outputs are valid.
REQ-012 win_ready  input  1  consumer takes the window when win_valid && win_ready.
REQ-013 win0..win8  output  PIX_W each  3x3 window, row-major; win0 is top-left and win8 is bottom-right. This ordering matches the in0..in8 inputs of sobel.
REQ-014 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-015 SHALL keep a column counter col (0..IMG_WIDTH-1) and a row counter row (0..IMG_HEIGHT-1), both addressing the next pixel to be accepted.
REQ-016 On each accepted pixel, col SHALL increment; at IMG_WIDTH-1, col SHALL wrap to 0 and row SHALL increment.
REQ-017 On the last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1), both counters SHALL return to 0 and frame_done SHALL pulse high for exactly the next cycle.
REQ-018 An accepted pixel with sof=1 SHALL be treated as position (0,0); the counters SHALL then continue from (0,1). A partial previous frame is abandoned with no frame_done pulse.
REQ-019 SHALL hold two IMG_WIDTH-deep line buffers (rows r-1 and r-2) and a 3x3 shift register of the most recent three columns.
REQ-020 An accepted pixel at (r,c) with r>=2 and c>=2 SHALL produce exactly one window centred on (r-1,c-1). In that window, win8 = pixel(r,c) and win0 = pixel(r-2,c-2).
REQ-021 A pixel with r<2 or c<2 SHALL produce no window. This gives (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-022 The window registers SHALL load, and win_valid SHALL rise, on the clock edge that accepts the completing pixel; latency is 1 cycle.
REQ-023 pix_ready SHALL equal !win_valid || win_ready, so no window is ever dropped or overwritten.
REQ-024 While win_valid=1 and win_ready=0, win0..win8 SHALL hold stable.
REQ-025 win_valid SHALL clear on a handshake unless a new window loads in the same cycle.
REQ-026 Pixel values SHALL pass through unmodified at full PIX_W width, with no arithmetic applied.

Reset
REQ-027 On rst=1, col, row, win_valid, frame_done and win0..win8 SHALL go to 0 immediately, independent of clk.
REQ-028 Line-buffer contents SHALL NOT be reset; they are never visible because of REQ-021.
REQ-029 Reset mid-frame SHALL discard the partial frame. The first pixel after reset is position (0,0).

Configuration
REQ-030 The macro SOBEL_WIN_COUNT_EN SHALL be supported. When defined, the block SHALL add an output win_count (20 bits) that increments on each window handshake, clears to 0 on reset, and clears when a pixel with sof=1 is accepted (the count then restarts from 0). When undefined, the port and its logic SHALL be absent.

Verification
REQ-031 Config IMG_WIDTH=4, IMG_HEIGHT=4; feed pixels 0..15 with sof on pixel 0 and win_ready=1 -> 4 windows: {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}; frame_done pulses once, the cycle after pixel 15 is accepted.
REQ-032 Same frame with win_ready=0 for 5 cycles after the first window -> win0..win8 hold {0,1,2,4,5,6,8,9,10} and pix_ready=0 throughout; after win_ready=1, the remaining windows follow with no loss.
REQ-033 Random pix_valid gaps, two back-to-back frames -> each frame yields the same 4 windows in order and exactly 2 frame_done pulses occur.
REQ-034 Assert sof on the 7th pixel of a frame, then send 16 pixels 100..115 -> windows are computed from 100..115 only, the first being {100,101,102,104,105,106,108,109,110}.
REQ-035 Assert rst asynchronously while win_valid=1 -> win_valid=0 and win0..win8=0 before the next edge; the following 16-pixel frame is correct.
REQ-036 With SOBEL_WIN_COUNT_EN defined, one full frame -> win_count=4; after sof on the next frame -> win_count=0.
